// File: rtl/dnn_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_accel_pkg
// Description : Shared FSM encoding and hold-limit constants for the on-chip
//               memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_accel_pkg;

    localparam int unsigned c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_OWN0 = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_OWN1 = 2'd2;

    localparam int unsigned c_HOLD_W           = 8;
    localparam int unsigned c_MAX_HOLD_DEFAULT = 8;
    localparam int unsigned c_MAX_HOLD_LIMIT   = 255;

    // Saturating increment of the owner's consecutive-grant count.
    function automatic logic [c_HOLD_W-1:0] hold_inc(
        input logic [c_HOLD_W-1:0] cnt,
        input logic [c_HOLD_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + c_HOLD_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant2
// Description : Two-way round-robin grant with a bounded ownership hold count.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
    import dnn_accel_pkg::*;
#(
    parameter int unsigned MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_grant0,
    output logic o_grant1
);

    localparam int unsigned c_HOLD_CLAMP =
        (MAX_HOLD < 1) ? 1 : ((MAX_HOLD > c_MAX_HOLD_LIMIT) ? c_MAX_HOLD_LIMIT : MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(c_HOLD_CLAMP);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_ptr;
    logic [c_HOLD_W-1:0]  r_hold;
    logic                 w_g0;
    logic                 w_g1;

    // Owner keeps the RAM until its run hits the limit and the other side waits.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        case (r_state)
            c_ST_OWN0: begin
                if (i_req0 && ((r_hold < c_HOLD_MAX) || !i_req1)) begin
                    w_g0 = 1'b1;
                end else if (i_req1) begin
                    w_g1 = 1'b1;
                end
            end
            c_ST_OWN1: begin
                if (i_req1 && ((r_hold < c_HOLD_MAX) || !i_req0)) begin
                    w_g1 = 1'b1;
                end else if (i_req0) begin
                    w_g0 = 1'b1;
                end
            end
            default: begin
                if (i_req0 && i_req1) begin
                    w_g0 = ~r_ptr;
                    w_g1 = r_ptr;
                end else begin
                    w_g0 = i_req0;
                    w_g1 = i_req1;
                end
            end
        endcase
    end

    // No access is granted while reset is held, so the RAM sees no strobes.
    assign o_grant0 = w_g0 & reset_n;
    assign o_grant1 = w_g1 & reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (w_g0) begin
                r_state <= c_ST_OWN0;
                r_hold  <= (r_state == c_ST_OWN0) ? hold_inc(r_hold, c_HOLD_MAX)
                                                  : c_HOLD_W'(1);
            end else if (w_g1) begin
                r_state <= c_ST_OWN1;
                r_hold  <= (r_state == c_ST_OWN1) ? hold_inc(r_hold, c_HOLD_MAX)
                                                  : c_HOLD_W'(1);
            end else begin
                r_state <= c_ST_IDLE;
                r_hold  <= '0;
            end
            if ((r_state == c_ST_IDLE) && i_req0 && i_req1) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_arbiter
// Description : Two-master arbiter for a shared single-port on-chip RAM with
//               one-cycle read latency and steered read-data-valid.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter
    import dnn_accel_pkg::*;
#(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic w_req0;
    logic w_req1;
    logic w_grant0;
    logic w_grant1;
    logic r_rvalid0;
    logic r_rvalid1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    rr_grant2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr_grant2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign m0_waitrequest = w_req0 & ~w_grant0;
    assign m1_waitrequest = w_req1 & ~w_grant1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (w_grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
        end else if (w_grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
        end
    end

    // Track which master owns the read returning from the RAM next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_grant0 & m0_read;
            r_rvalid1 <= w_grant1 & m1_read;
        end
    end

    // Gating with reset_n drops a read that is returning while reset is asserted.
    assign m0_readdatavalid = r_rvalid0 & reset_n;
    assign m1_readdatavalid = r_rvalid1 & reset_n;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_arbiter
// Description : Directed self-checking bench for onchip_mem_arbiter with a
//               behavioural single-port RAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_readdata;

    logic [31:0] ram [0:8191];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_readdata     (mem_readdata)
    );

    // Single-port RAM: byte-lane writes, registered one-cycle reads.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic idle_all();
        set_m0(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        set_m1(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int owner;
        int prev_owner;
        reset_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rv0", m0_readdatavalid, 1'b0);
        check("rst_rv1", m1_readdatavalid, 1'b0);
        check("rst_cs", mem_chipselect, 1'b0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_cs", mem_chipselect, 1'b0);
        check("idle_wr", mem_write, 1'b0);
        check("idle_addr", mem_address, 13'h0);
        check("idle_wait0", m0_waitrequest, 1'b0);
        check("idle_wait1", m1_waitrequest, 1'b0);

        // m0 write then m1 read of the same word
        next_cycle();
        set_m0(1'b0, 1'b1, 13'd5, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check("wr5_wait0", m0_waitrequest, 1'b0);
        check("wr5_cs", mem_chipselect, 1'b1);
        check("wr5_we", mem_write, 1'b1);
        check("wr5_addr", mem_address, 13'd5);
        check("wr5_data", mem_writedata, 32'hDEADBEEF);
        next_cycle();
        set_m0(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        set_m1(1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
        @(negedge clk);
        check("rd5_wait1", m1_waitrequest, 1'b0);
        check("rd5_we", mem_write, 1'b0);
        check("rd5_addr", mem_address, 13'd5);
        check("wr5_no_rv0", m0_readdatavalid, 1'b0);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("rd5_rv1", m1_readdatavalid, 1'b1);
        check("rd5_data", m1_readdata, 32'hDEADBEEF);
        check("rd5_rv0", m0_readdatavalid, 1'b0);

        // Partial write at the top address
        next_cycle();
        set_m1(1'b0, 1'b1, 13'h1FFF, 4'hF, 32'hFFFFFFFF);
        @(negedge clk);
        check("top_fill_addr", mem_address, 13'h1FFF);
        next_cycle();
        set_m1(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        set_m0(1'b0, 1'b1, 13'h1FFF, 4'h3, 32'h0000AAAA);
        @(negedge clk);
        check("top_wr_wait0", m0_waitrequest, 1'b0);
        check("top_wr_be", mem_byteenable, 4'h3);
        next_cycle();
        set_m0(1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0);
        @(negedge clk);
        check("top_rd_addr", mem_address, 13'h1FFF);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("top_rd_rv0", m0_readdatavalid, 1'b1);
        check("top_rd_data", m0_readdata, 32'hFFFFAAAA);

        // Owner drops while the other master requests: same-cycle handover
        next_cycle();
        set_m0(1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
        @(negedge clk);
        check("own0_wait0", m0_waitrequest, 1'b0);
        next_cycle();
        set_m0(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        set_m1(1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0);
        @(negedge clk);
        check("handover_wait1", m1_waitrequest, 1'b0);
        check("handover_addr", mem_address, 13'h1FFF);
        check("handover_rv0", m0_readdatavalid, 1'b1);
        check("handover_d0", m0_readdata, 32'hDEADBEEF);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("handover_rv1", m1_readdatavalid, 1'b1);
        check("handover_d1", m1_readdata, 32'hFFFFAAAA);
        check("handover_rv0_off", m0_readdatavalid, 1'b0);

        // Continuous contention from IDLE, pointer at m0: 8 and 8 alternating
        next_cycle();
        set_m0(1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
        set_m1(1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0);
        prev_owner = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            owner = (i / 8) % 2;
            check($sformatf("rr_wait0_%0d", i), m0_waitrequest, owner != 0);
            check($sformatf("rr_wait1_%0d", i), m1_waitrequest, owner != 1);
            if (i > 0) begin
                check($sformatf("rr_rv0_%0d", i), m0_readdatavalid, prev_owner == 0);
                check($sformatf("rr_data_%0d", i), m0_readdata,
                      (prev_owner == 0) ? 32'hDEADBEEF : 32'hFFFFAAAA);
            end
            prev_owner = owner;
            next_cycle();
        end
        idle_all();
        @(negedge clk);
        check("rr_tail_rv1", m1_readdatavalid, 1'b1);
        check("rr_tail_cs", mem_chipselect, 1'b0);

        // Reset right after an m1 read accept; pointer was left at m1
        next_cycle();
        set_m1(1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
        @(negedge clk);
        check("pre_rst_wait1", m1_waitrequest, 1'b0);
        next_cycle();
        reset_n = 1'b0;
        idle_all();
        @(negedge clk);
        check("mid_rst_rv1", m1_readdatavalid, 1'b0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rv1", m1_readdatavalid, 1'b0);
        check("post_rst_rv0", m0_readdatavalid, 1'b0);
        next_cycle();
        set_m0(1'b1, 1'b0, 13'd5, 4'h0, 32'h0);
        set_m1(1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0);
        @(negedge clk);
        check("post_rst_tie_wait0", m0_waitrequest, 1'b0);
        check("post_rst_tie_wait1", m1_waitrequest, 1'b1);
        check("post_rst_tie_addr", mem_address, 13'd5);

        // m0 alone past the limit, then m1 joins: count saturated, m1 wins
        next_cycle();
        set_m1(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("post_rst_rv0_data", m0_readdata, 32'hDEADBEEF);
        check("post_rst_rv0_pulse", m0_readdatavalid, 1'b1);
        repeat (9) next_cycle();
        set_m1(1'b1, 1'b0, 13'h1FFF, 4'h0, 32'h0);
        @(negedge clk);
        check("sat_wait1", m1_waitrequest, 1'b0);
        check("sat_wait0", m0_waitrequest, 1'b1);
        next_cycle();
        idle_all();
        @(negedge clk);
        check("sat_rv1", m1_readdatavalid, 1'b1);
        check("sat_rv0", m0_readdatavalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
